// File: rtl/cmd_pkg.sv
// Shared types and constants for the command-link UART blocks.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: 2-FF synchroniser, mid-bit sampling FSM, byte_done / frame_err pulses.
module uart_rx_core
  import cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic                 o_byte_done,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_frame_err
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  rx_state_t            w_next_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [CW-1:0]        w_last;
  logic                 w_tick;
  logic                 w_cnt_clr;
  logic                 w_shift_en;
  logic                 w_bit_clr;
  logic                 w_bit_inc;

  // START waits only half a bit so that later samples land mid-bit.
  assign w_last = (r_state == START) ? CW'(HALF_BIT - 1) : CW'(CLKS_PER_BIT - 1);
  assign w_tick = (r_cnt == w_last);
  assign o_data = r_shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_bit_inc) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_byte_done  = 1'b0;
    o_frame_err  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        w_bit_clr = 1'b1;
        if (!r_sync2) w_next_state = START;
      end
      START: begin
        if (w_tick) begin
          w_cnt_clr    = 1'b1;
          w_next_state = r_sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            w_bit_clr    = 1'b1;
            w_next_state = STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_cnt_clr = 1'b1;
          if (!r_sync2) begin
            o_frame_err  = 1'b1;
            w_next_state = WAIT_IDLE;
          end else if (r_bit_idx == 3'(STOP_BITS - 1)) begin
            o_byte_done  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        w_cnt_clr = 1'b1;
        if (r_sync2) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/cmd_rx.sv
// Command receive front end: UART deserialiser feeding a show-ahead receive FIFO.
module cmd_rx
  import cmd_pkg::*;
#(
  parameter int unsigned MAIN_CLK_FREQ = 120000000,
  parameter int unsigned UART_BAUD     = 115200,
  parameter int unsigned FIFO_AW       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic                 data_read,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 frame_err,
  output logic                 overwrite_flag
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(MAIN_CLK_FREQ, UART_BAUD);
  localparam int unsigned DEPTH        = 2 ** FIFO_AW;

  logic                 w_byte_done;
  logic [DATA_BITS-1:0] w_rx_byte;
  logic                 w_frame_err;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]     r_wr_ptr;
  logic [FIFO_AW:0]     r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic                 r_ovf;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_rd_en;
  logic                 w_wr_en;
  logic                 w_drop;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (uart_rx),
    .o_byte_done(w_byte_done),
    .o_data     (w_rx_byte),
    .o_frame_err(w_frame_err)
  );

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]) &&
                   (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]);
  assign w_rd_en = data_read && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_wr_en = w_byte_done && (!w_full || w_rd_en);
  assign w_drop  = w_byte_done && w_full && !w_rd_en;

  assign data           = w_empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign data_valid     = !w_empty;
  assign fifo_count     = r_count;
  assign frame_err      = w_frame_err;
  assign overwrite_flag = r_ovf;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_rx.sv
// Self-checking bench for cmd_rx: directed scenarios plus random frames against a queue model.
module tb_cmd_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       data_read;
  logic       err_clr;
  logic [7:0] data;
  logic       data_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overwrite_flag;

  int         checks   = 0;
  int         errors   = 0;
  int         ferr_cnt = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  cmd_rx #(
    .MAIN_CLK_FREQ(16),
    .UART_BAUD    (1),
    .FIFO_AW      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .data_read     (data_read),
    .err_clr       (err_clr),
    .data          (data),
    .data_valid    (data_valid),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .overwrite_flag(overwrite_flag)
  );

  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".count"}, 32'(fifo_count), exp_q.size());
    chk({tag, ".valid"}, 32'(data_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ".data"}, 32'(data), 32'(exp_q[0]));
    chk({tag, ".ovf"}, 32'(overwrite_flag), 32'(exp_ovf));
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(data_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({tag, ".data"}, 32'(data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  // mode: 0 none, 1 read in byte_done cycle, 2 err_clr in byte_done cycle,
  // 3 check outputs one cycle after byte_done
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned mode,
                            input int unsigned hold_low, input int unsigned gap);
    int  f0;
    bit  seen;
    bit  chk_next;
    bit  dropped;
    f0       = ferr_cnt;
    seen     = 1'b0;
    chk_next = 1'b0;
    uart_rx  = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(CPB);
    end
    uart_rx = stop;
    for (int c = 0; c < int'(CPB); c++) begin
      @(negedge clk);
      if (chk_next) begin
        chk_next = 1'b0;
        chk("next.valid", 32'(data_valid), 32'd1);
        chk("next.data", 32'(data), 32'(b));
        chk("next.count", 32'(fifo_count), exp_q.size() + 1);
      end
      if (!seen && dut.u_core.o_byte_done === 1'b1) begin
        seen = 1'b1;
        if (mode == 1) begin
          data_read = 1'b1;
          if (exp_q.size() != 0) begin
            chk("rd_at_done", 32'(data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
        if (mode == 2) err_clr = 1'b1;
        if (mode == 3) chk_next = 1'b1;
      end
      @(posedge clk);
      #1;
      data_read = 1'b0;
      err_clr   = 1'b0;
    end
    if (hold_low != 0) begin
      uart_rx = 1'b0;
      cyc(hold_low);
    end
    uart_rx = 1'b1;
    if (stop) begin
      dropped = (exp_q.size() >= DEPTH);
      if (!dropped) exp_q.push_back(b);
      if (dropped) exp_ovf = 1'b1;
      else if (mode == 2) exp_ovf = 1'b0;
    end
    cyc(gap);
    chk("frame_err_pulses", 32'(ferr_cnt - f0), stop ? 32'd0 : 32'd1);
  endtask

  initial begin
    int f0;
    rst       = 1'b0;
    uart_rx   = 1'b1;
    data_read = 1'b0;
    err_clr   = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst.data", 32'(data), 32'h00);
    chk("rst.valid", 32'(data_valid), 32'd0);
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.ferr", 32'(frame_err), 32'd0);
    chk("rst.ovf", 32'(overwrite_flag), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(20);

    // 1: single good frame, then read it back
    send_frame(8'hA5, 1'b1, 3, 0, 8);
    check_state("t1");
    do_read("t1.rd");
    check_state("t1.empty");

    // 2: short glitch is a false start
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    cyc(4);
    uart_rx = 1'b1;
    cyc(40);
    check_state("t2");
    chk("t2.ferr", 32'(ferr_cnt - f0), 32'd0);

    // 3: bad stop bit with break, then a good frame
    send_frame(8'h3C, 1'b0, 0, 40, 10);
    send_frame(8'h11, 1'b1, 0, 0, 10);
    check_state("t3");
    while (exp_q.size() != 0) do_read("t3.rd");
    check_state("t3.empty");

    // 4: overflow; err_clr in the dropping cycle loses to the set
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 0, 0, 4);
    check_state("t4.full");
    send_frame(8'h10, 1'b1, 2, 0, 6);
    check_state("t4.ovf");
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    exp_ovf = 1'b0;
    check_state("t4.clr");

    // 5: full FIFO with a read in the byte_done cycle accepts the byte
    send_frame(8'h77, 1'b1, 1, 0, 6);
    check_state("t5");
    while (exp_q.size() != 0) do_read("t5.rd");
    check_state("t5.empty");

    // random frames, random error stop bits, random reads
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      logic       st;
      b  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(b, st, $urandom_range(0, 2), 0, 4 + $urandom_range(0, 16));
      check_state("rnd");
      repeat ($urandom_range(0, 2)) if (exp_q.size() != 0) do_read("rnd.rd");
    end

    // 6: reset in the middle of 0xF0, released while the line is high
    send_frame(8'hC3, 1'b1, 0, 0, 6);
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 3; i++) cyc(CPB);
    cyc(CPB / 2);
    rst = 1'b0;
    cyc(CPB / 2);
    uart_rx = 1'b1;
    cyc(CPB / 2);
    @(negedge clk);
    chk("t6.rst.data", 32'(data), 32'h00);
    chk("t6.rst.valid", 32'(data_valid), 32'd0);
    chk("t6.rst.count", 32'(fifo_count), 32'd0);
    chk("t6.rst.ferr", 32'(frame_err), 32'd0);
    chk("t6.rst.ovf", 32'(overwrite_flag), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    cyc(CPB / 2 + 3 * CPB + CPB + 10);
    check_state("t6.idle");
    chk("t6.ferr", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h5A, 1'b1, 0, 0, 8);
    check_state("t6.5a");
    do_read("t6.rd");
    check_state("t6.empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_rx.md
# cmd_rx

Receive-side command front end: deserialises 8N1 UART frames from `uart_rx`, checks the start and stop bits, and buffers good bytes in a 16-entry receive FIFO. Downstream command logic reads bytes through a show-ahead read port. It is the receive counterpart of `cmd_tx` and uses the same clock domain and baud parameters.

## Interface
- `MAIN_CLK_FREQ`, default 120000000: frequency of `clk` in Hz.
- `UART_BAUD`, default 115200: line baud rate. `CLKS_PER_BIT = MAIN_CLK_FREQ / UART_BAUD`, integer division, must be ≥ 8.
- `FIFO_AW`, default 4: FIFO address width. Depth is `2**FIFO_AW`.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: synchronous, active-low reset.
- `uart_rx`  in  1: asynchronous serial input, idle high.
- `data_read`  in  1: pops the head byte when `data_valid` is 1. Ignored when the FIFO is empty.
- `err_clr`  in  1: one-cycle pulse that clears `overwrite_flag`.
- `data`  out  8: head byte of the FIFO. Valid while `data_valid` is 1.
- `data_valid`  out  1: FIFO not empty.
- `fifo_count`  out  FIFO_AW+1: current occupancy.
- `frame_err`  out  1: one-cycle pulse when a frame has a bad stop bit.
- `overwrite_flag`  out  1: sticky flag, set when a good byte is dropped because the FIFO is full.

## Operation
- `uart_rx` passes through a 2-FF synchroniser. The synchroniser reset value is 1.
- The deserialiser FSM has states IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when the synchronised line is 0, clear the bit counter and go to START.
  - START: count `(CLKS_PER_BIT-1)/2` cycles, then sample. If the sample is 1, it was a false start; return to IDLE. If 0, go to DATA.
  - DATA: count `CLKS_PER_BIT` cycles, then sample. Bits are LSB first into the shift register. After bit 7, go to STOP.
  - STOP: count `CLKS_PER_BIT` cycles, then sample. If 1, pulse `byte_done` for one cycle and go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line is 1, then go to IDLE. This suppresses break conditions.
- FIFO:
  - Circular buffer with FIFO_AW+1-bit read and write pointers; the MSB is the wrap bit.
  - Full when the addresses are equal and the wrap bits differ. Empty when the pointers are equal.
  - Write when `byte_done` is 1 and the FIFO is not full.
  - Full with a simultaneous `data_read`: the write is accepted and the count is unchanged.
  - Full with no read: the byte is dropped and `overwrite_flag` is set.
  - Empty with simultaneous `byte_done` and `data_read`: only the write happens.
- `overwrite_flag`: if a set event and `err_clr` occur in the same cycle, set wins.
- Reset values:
  - `data_valid` = 0, `fifo_count` = 0, `frame_err` = 0, `overwrite_flag` = 0, `data` = 0x00.
  - FSM = IDLE, pointers = 0.
- Reset asserted mid-frame aborts the frame. After reset the block waits for the next falling edge; no partial byte is written.

## Timing
- Start-bit detection lags the pin by 2 cycles (synchroniser), plus 1 cycle for the IDLE→START transition.
- `byte_done` fires in the stop-bit sample cycle. The FIFO write happens on the next edge. `data_valid` and `data` update in the cycle after `byte_done`.
- `data_read` sampled at edge N: `data` shows the next entry, or `data_valid` drops, after edge N.
- `frame_err` is high for exactly one cycle, in the stop-bit sample cycle.
- `fifo_count` is registered and updates on the same edge as the pointer moves.

## Structure
- Shared package `cmd_pkg` holds:
  - the FSM state enum `rx_state_t` (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the `CLKS_PER_BIT` computation function;
  - the frame format constants `DATA_BITS=8` and `STOP_BITS=1`.
- Sub-module `uart_rx_core`: the synchroniser plus FSM, producing a `byte_done` pulse, the received byte and `frame_err`.
- The FIFO is coded inline in `cmd_rx`. It uses FIFO_AW+1-bit pointers and a registered `fifo_count`.

## Test plan
All scenarios use `MAIN_CLK_FREQ=16`, `UART_BAUD=1`, so `CLKS_PER_BIT=16`.
1. Frame 0xA5 with a good stop bit → `data`=0xA5, `data_valid`=1, `fifo_count`=1 one cycle after `byte_done`; `data_read` pulse → `data_valid`=0.
2. `uart_rx` low for 4 cycles, then high → no `byte_done`, FSM back in IDLE, `fifo_count`=0.
3. Frame 0x3C with stop bit 0, line held low 40 more cycles, then a good 0x11 → one `frame_err` pulse, no write for 0x3C, only 0x11 queued.
4. Frames 0x00–0x10 (17 bytes) with no reads → `fifo_count`=16, `overwrite_flag`=1, reads return 0x00–0x0F in order; `err_clr` → flag = 0.
5. FIFO full with `data_read` asserted in the `byte_done` cycle of 0x77 → count stays 16, `overwrite_flag` stays 0, 0x77 is read last.
6. `rst`=0 during bit 3 of 0xF0, then released, then 0x5A sent → all outputs at reset values, only 0x5A received.
